seq_multiplier: RTL



---
 rtl/seq_multiplier_pkg.sv | 15 +
 rtl/seq_multiplier_if.sv | 36 +++
 rtl/seq_multiplier_step.sv | 28 ++
 rtl/seq_multiplier.sv | 116 +++++++++++
 4 files changed

// File: rtl/seq_multiplier_pkg.sv
// rtl/seq_multiplier_pkg.sv - shared FSM state type and counter sizing helper for seq_multiplier
package seq_mul_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX,
        DONE
    } state_t;

    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/seq_multiplier_if.sv
// rtl/seq_multiplier_if.sv - operand/result handshake bundle; SEQ_MUL_OVF_EN adds the ovf flag
interface seq_multiplier_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] rs_data;
    logic [WIDTH-1:0] rd_data;
    logic             signed_mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] p_lo;
    logic [WIDTH-1:0] p_hi;
    logic             busy;
`ifdef SEQ_MUL_OVF_EN
    logic             ovf;

    modport master (
        output in_valid, rs_data, rd_data, signed_mode, out_ready,
        input  in_ready, out_valid, p_lo, p_hi, busy, ovf
    );
    modport slave (
        input  in_valid, rs_data, rd_data, signed_mode, out_ready,
        output in_ready, out_valid, p_lo, p_hi, busy, ovf
    );
`else
    modport master (
        output in_valid, rs_data, rd_data, signed_mode, out_ready,
        input  in_ready, out_valid, p_lo, p_hi, busy
    );
    modport slave (
        input  in_valid, rs_data, rd_data, signed_mode, out_ready,
        output in_ready, out_valid, p_lo, p_hi, busy
    );
`endif
endinterface

// File: rtl/seq_multiplier_step.sv
// rtl/seq_multiplier_step.sv - one shift-add step: folds BITS_PER_CYCLE multiplier bits into the accumulator
module mul_step #(
    parameter int WIDTH          = 16,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic [2*WIDTH-1:0]        i_acc,
    input  logic [WIDTH-1:0]          i_mcand,
    input  logic [BITS_PER_CYCLE-1:0] i_mbits,
    output logic [2*WIDTH-1:0]        o_acc
);
    localparam int B = BITS_PER_CYCLE;

    logic [WIDTH+B-1:0]   w_pp;
    logic [2*WIDTH+B-1:0] w_sum;

    // The product grows in from the top: add into the upper half, then shift right by B.
    always_comb begin
        w_pp = '0;
        for (int j = 0; j < B; j++) begin
            if (i_mbits[j]) begin
                w_pp = w_pp + ({{B{1'b0}}, i_mcand} << j);
            end
        end
        w_sum = {{B{1'b0}}, i_acc} + {w_pp, {WIDTH{1'b0}}};
        o_acc = w_sum[2*WIDTH+B-1:B];
    end

endmodule

// File: rtl/seq_multiplier.sv
// rtl/seq_multiplier.sv - multi-cycle signed/unsigned shift-add multiplier; SEQ_MUL_OVF_EN enables ovf
module seq_multiplier
    import seq_mul_pkg::*;
#(
    parameter int WIDTH          = 16,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    seq_multiplier_if.slave  bus
);
    localparam int N  = WIDTH / BITS_PER_CYCLE;
    localparam int CW = cnt_width(N);

    if (WIDTH % BITS_PER_CYCLE != 0) begin : g_bpc_check
        $error("BITS_PER_CYCLE must divide WIDTH");
    end

    state_t               r_state, w_next;
    logic [CW-1:0]        r_cnt;
    logic [2*WIDTH-1:0]   r_acc, w_acc_next, w_fix;
    logic [WIDTH-1:0]     r_mcand, r_mplier;
    logic [WIDTH-1:0]     r_p_lo, r_p_hi;
    logic [WIDTH-1:0]     w_rs_mag, w_rd_mag;
    logic                 r_neg, r_signed, r_ovf;
    logic                 w_in_ready, w_out_valid, w_busy, w_accept, w_last, w_ovf;

    // Magnitude of the signed minimum is still representable as a WIDTH-bit unsigned value.
    assign w_rs_mag = (bus.signed_mode && bus.rs_data[WIDTH-1]) ? -bus.rs_data : bus.rs_data;
    assign w_rd_mag = (bus.signed_mode && bus.rd_data[WIDTH-1]) ? -bus.rd_data : bus.rd_data;
    assign w_accept = bus.in_valid && w_in_ready;
    assign w_last   = (r_cnt == CW'(N - 1));
    assign w_fix    = r_neg ? (~r_acc + {{(2*WIDTH-1){1'b0}}, 1'b1}) : r_acc;
    assign w_ovf    = r_signed ? (w_fix[2*WIDTH-1:WIDTH] != {WIDTH{w_fix[WIDTH-1]}})
                               : (w_fix[2*WIDTH-1:WIDTH] != '0);

    mul_step #(
        .WIDTH          (WIDTH),
        .BITS_PER_CYCLE (BITS_PER_CYCLE)
    ) u_step (
        .i_acc   (r_acc),
        .i_mcand (r_mcand),
        .i_mbits (r_mplier[BITS_PER_CYCLE-1:0]),
        .o_acc   (w_acc_next)
    );

    always_comb begin
        w_next      = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        w_busy      = 1'b0;
        case (r_state)
            IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) w_next = RUN;
            end
            RUN: begin
                w_busy = 1'b1;
                if (w_last) w_next = FIX;
            end
            FIX: begin
                w_busy = 1'b1;
                w_next = DONE;
            end
            DONE: begin
                w_out_valid = 1'b1;
                w_in_ready  = bus.out_ready;
                if (bus.out_ready) w_next = bus.in_valid ? RUN : IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_neg    <= 1'b0;
            r_signed <= 1'b0;
            r_p_lo   <= '0;
            r_p_hi   <= '0;
            r_ovf    <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_mcand  <= w_rs_mag;
                r_mplier <= w_rd_mag;
                r_neg    <= bus.signed_mode && (bus.rs_data[WIDTH-1] ^ bus.rd_data[WIDTH-1]);
                r_signed <= bus.signed_mode;
                r_acc    <= '0;
                r_cnt    <= '0;
            end else if (r_state == RUN) begin
                r_acc    <= w_acc_next;
                r_mplier <= r_mplier >> BITS_PER_CYCLE;
                r_cnt    <= r_cnt + CW'(1);
            end else if (r_state == FIX) begin
                r_p_lo <= w_fix[WIDTH-1:0];
                r_p_hi <= w_fix[2*WIDTH-1:WIDTH];
                r_ovf  <= w_ovf;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.busy      = w_busy;
    assign bus.p_lo      = r_p_lo;
    assign bus.p_hi      = r_p_hi;
`ifdef SEQ_MUL_OVF_EN
    assign bus.ovf       = r_ovf;
`endif

endmodule
